// File: rtl/ins_fetch.sv
// ins_fetch: instruction fetch unit with a 2-entry {ins, pc, adel} FIFO
// feeding the control decoder, a one-outstanding-request memory port and
// redirect handling (IDLE / WAIT / FLUSH).
// Optional feature: define IFETCH_ADEL_EN to report misaligned redirect
// targets as an address-error entry instead of silently aligning them.
module ins_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins,
  output logic        ins_valid,
  input  logic        ins_ready,
  output logic [31:0] pc_out,
  output logic        ins_adel,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  typedef enum logic [1:0] {IDLE, WAIT, FLUSH} state_t;

  state_t      state, state_nx;
  logic [31:0] fetch_pc, fetch_pc_nx;
  logic [31:0] addr_nx;
  logic        halt, halt_nx;

  // Redirect target as seen by the fetch logic, and whether it is misaligned
  logic [31:0] rpc;
  logic        rpc_bad;

  // FIFO storage and control
  logic [31:0] ins_q [2];
  logic [31:0] pc_q  [2];
  logic        rd_ptr, wr_ptr, wr_slot;
  logic [1:0]  count, cnt_pop, cnt_push;
  logic        push, pop, flush;
  logic [31:0] push_ins, push_pc;

`ifdef IFETCH_ADEL_EN
  logic [1:0]  adel_q;
  assign rpc     = redirect_pc;
  assign rpc_bad = |redirect_pc[1:0];
`else
  assign rpc     = redirect_pc & 32'hFFFF_FFFC;
  assign rpc_bad = 1'b0;
`endif

  assign imem_req  = (state == WAIT) || (state == FLUSH);
  assign ins_valid = (count != 2'd0);
  assign ins       = ins_valid ? ins_q[rd_ptr] : 32'h0;
  assign pc_out    = ins_valid ? pc_q[rd_ptr]  : 32'h0;
`ifdef IFETCH_ADEL_EN
  assign ins_adel  = ins_valid & adel_q[rd_ptr];
`else
  assign ins_adel  = 1'b0;
`endif

  // A redirect flushes the FIFO, so a pop in that cycle is dropped
  assign pop      = ins_valid && ins_ready && !redirect;
  assign cnt_pop  = count - {1'b0, pop};
  assign cnt_push = count + 2'd1 - {1'b0, pop};
  // After a flush the only possible push (address-error entry) lands in slot 0
  assign wr_slot  = flush ? 1'b0 : wr_ptr;

  // Next-state, next fetch address and FIFO push/flush decisions
  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    addr_nx     = imem_addr;
    halt_nx     = halt;
    push        = 1'b0;
    flush       = 1'b0;
    push_ins    = imem_rdata;
    push_pc     = imem_addr;
    if (redirect) begin
      flush       = 1'b1;
      fetch_pc_nx = rpc;
      halt_nx     = rpc_bad;
      if (rpc_bad) begin
        // Address-error entry is synthesised locally, no memory access
        push     = 1'b1;
        push_ins = 32'h0;
        push_pc  = rpc;
      end
      case (state)
        WAIT, FLUSH: begin
          if (imem_ack) begin
            // Outstanding response is discarded; port is free again
            state_nx = rpc_bad ? IDLE : WAIT;
            addr_nx  = rpc;
          end else begin
            // Old request must complete before the new one may issue
            state_nx = FLUSH;
          end
        end
        default: begin
          state_nx = rpc_bad ? IDLE : WAIT;
          addr_nx  = rpc;
        end
      endcase
    end else begin
      case (state)
        WAIT: begin
          if (imem_ack) begin
            push        = 1'b1;
            fetch_pc_nx = fetch_pc + 32'd4;
            if (cnt_push < 2'd2) begin
              addr_nx = fetch_pc + 32'd4;
            end else begin
              state_nx = IDLE;
            end
          end
        end
        FLUSH: begin
          if (imem_ack) begin
            state_nx = halt ? IDLE : WAIT;
            addr_nx  = fetch_pc;
          end
        end
        default: begin
          if (!halt && (cnt_pop < 2'd2)) begin
            state_nx = WAIT;
            addr_nx  = fetch_pc;
          end
        end
      endcase
    end
  end

  // FSM state, fetch address and request address registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      fetch_pc  <= RESET_PC;
      imem_addr <= 32'h0;
      halt      <= 1'b0;
    end else begin
      state     <= state_nx;
      fetch_pc  <= fetch_pc_nx;
      imem_addr <= addr_nx;
      halt      <= halt_nx;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= push;
      count  <= {1'b0, push};
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  // FIFO payload; outputs are masked while empty so no data reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      ins_q[wr_slot] <= push_ins;
      pc_q[wr_slot]  <= push_pc;
`ifdef IFETCH_ADEL_EN
      adel_q[wr_slot] <= redirect;
`endif
    end
  end

endmodule

// File: tb/tb_ins_fetch.sv
// Directed testbench for ins_fetch (default build, IFETCH_ADEL_EN undefined).
// Memory model returns addr ^ 32'hA5A5_0000 after a programmable latency.
module tb_ins_fetch;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] ins;
  logic        ins_valid;
  logic        ins_ready;
  logic [31:0] pc_out;
  logic        ins_adel;
  logic        redirect;
  logic [31:0] redirect_pc;

  int          lat;
  int          lat_cnt;
  int          n_chk;
  int          n_fail;
  int          n_ack;
  int          n_forbid;
  logic [31:0] forbid_pc;

  ins_fetch #(.RESET_PC(32'h0000_3000)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .ins        (ins),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .pc_out     (pc_out),
    .ins_adel   (ins_adel),
    .redirect   (redirect),
    .redirect_pc(redirect_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory model: ack after lat waiting cycles, data derived from address
  assign imem_ack   = imem_req && (lat_cnt == lat);
  assign imem_rdata = imem_addr ^ KEY;

  always @(posedge clk) begin
    if (reset || imem_ack) lat_cnt <= 0;
    else if (imem_req)     lat_cnt <= lat_cnt + 1;
  end

  // Event counters: memory acks and appearances of a discarded pc
  always @(posedge clk) begin
    if (!reset) begin
      if (imem_ack) n_ack <= n_ack + 1;
      if (ins_valid && pc_out == forbid_pc) n_forbid <= n_forbid + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int latency);
    reset    = 1'b1;
    redirect = 1'b0;
    lat      = latency;
    tick();
    tick();
  endtask

  task automatic wait_req(input logic [31:0] a, input string tag);
    int k;
    for (k = 0; k < 60; k++) begin
      if (imem_req && imem_addr == a) break;
      tick();
    end
    chk(tag, {31'h0, (k < 60)}, 32'h1);
  endtask

  task automatic wait_valid(input string tag);
    int k;
    for (k = 0; k < 60; k++) begin
      if (ins_valid) break;
      tick();
    end
    chk(tag, {31'h0, (k < 60)}, 32'h1);
  endtask

  task automatic do_redirect(input logic [31:0] a);
    redirect    = 1'b1;
    redirect_pc = a;
    tick();
    redirect    = 1'b0;
  endtask

  initial begin
    int a0;
    int k;
    n_chk       = 0;
    n_fail      = 0;
    n_ack       = 0;
    n_forbid    = 0;
    lat_cnt     = 0;
    forbid_pc   = 32'hDEAD_BEEF;
    ins_ready   = 1'b1;
    redirect_pc = 32'h0;

    // ---- reset state and streaming at one instruction per cycle ----
    do_reset(0);
    chk("rst_req",   {31'h0, imem_req},  32'h0);
    chk("rst_addr",  imem_addr,          32'h0);
    chk("rst_valid", {31'h0, ins_valid}, 32'h0);
    chk("rst_ins",   ins,                32'h0);
    chk("rst_pc",    pc_out,             32'h0);
    chk("rst_adel",  {31'h0, ins_adel},  32'h0);
    reset = 1'b0;
    tick();
    chk("s_req0",  {31'h0, imem_req}, 32'h1);
    chk("s_addr0", imem_addr, 32'h3000);
    tick();
    chk("s_addr1", imem_addr, 32'h3004);
    chk("s_pc0",   pc_out,    32'h3000);
    chk("s_ins0",  ins,       32'h3000 ^ KEY);
    tick();
    chk("s_addr2", imem_addr, 32'h3008);
    chk("s_pc1",   pc_out,    32'h3004);
    tick();
    chk("s_pc2",   pc_out,    32'h3008);
    chk("s_ins2",  ins,       32'h3008 ^ KEY);

    // ---- decoder stall: FIFO fills to two and fetching stops ----
    do_reset(0);
    ins_ready = 1'b0;
    reset     = 1'b0;
    a0        = n_ack;
    for (k = 0; k < 6; k++) tick();
    chk("stall_acks",  n_ack - a0, 2);
    chk("stall_req",   {31'h0, imem_req},  32'h0);
    chk("stall_valid", {31'h0, ins_valid}, 32'h1);
    chk("stall_pc0",   pc_out, 32'h3000);
    ins_ready = 1'b1;
    tick();
    chk("resume_pc1",   pc_out,    32'h3004);
    chk("resume_addr",  imem_addr, 32'h3008);
    tick();
    chk("resume_pc2",   pc_out,    32'h3008);
    chk("resume_ins2",  ins,       32'h3008 ^ KEY);

    // ---- redirect while waiting on a slow memory ----
    do_reset(3);
    reset     = 1'b0;
    forbid_pc = 32'h3008;
    wait_req(32'h3008, "slow_reach_3008");
    a0 = n_forbid;
    do_redirect(32'h4000);
    chk("flush_req",   {31'h0, imem_req},  32'h1);
    chk("flush_addr",  imem_addr, 32'h3008);
    chk("flush_valid", {31'h0, ins_valid}, 32'h0);
    for (k = 0; k < 60; k++) begin
      if (imem_addr != 32'h3008) break;
      tick();
    end
    chk("flush_next_addr", imem_addr, 32'h4000);
    chk("flush_next_req",  {31'h0, imem_req}, 32'h1);
    wait_valid("flush_valid_timeout");
    chk("flush_pc",  pc_out, 32'h4000);
    chk("flush_ins", ins,    32'h4000 ^ KEY);
    chk("flush_discard", n_forbid - a0, 0);

    // ---- redirect coinciding with a memory ack ----
    do_reset(2);
    reset     = 1'b0;
    forbid_pc = 32'h3004;
    for (k = 0; k < 60; k++) begin
      if (imem_ack && imem_addr == 32'h3004) break;
      tick();
    end
    chk("ackredir_reach", {31'h0, (k < 60)}, 32'h1);
    a0 = n_forbid;
    do_redirect(32'h5000);
    chk("ackredir_valid", {31'h0, ins_valid}, 32'h0);
    chk("ackredir_req",   {31'h0, imem_req},  32'h1);
    chk("ackredir_addr",  imem_addr, 32'h5000);
    wait_valid("ackredir_valid_timeout");
    chk("ackredir_pc", pc_out, 32'h5000);
    chk("ackredir_discard", n_forbid - a0, 0);

    // ---- misaligned redirect target is aligned in the default build ----
    do_reset(0);
    reset = 1'b0;
    wait_req(32'h3008, "mis_reach_3008");
    do_redirect(32'h4002);
    chk("mis_addr",  imem_addr, 32'h4000);
    chk("mis_valid", {31'h0, ins_valid}, 32'h0);
    chk("mis_adel0", {31'h0, ins_adel},  32'h0);
    tick();
    chk("mis_pc",    pc_out, 32'h4000);
    chk("mis_adel1", {31'h0, ins_adel}, 32'h0);

    // ---- fetch address wraps at the top of the address space ----
    do_reset(0);
    reset = 1'b0;
    wait_req(32'h3004, "wrap_reach");
    do_redirect(32'hFFFF_FFFC);
    chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap_addr1", imem_addr, 32'h0000_0000);
    chk("wrap_pc0",   pc_out,    32'hFFFF_FFFC);
    tick();
    chk("wrap_pc1",   pc_out,    32'h0000_0000);
    chk("wrap_ins1",  ins,       32'h0000_0000 ^ KEY);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
